// File: rtl/simple_piso_tx_pkg.sv
// simple_piso_tx_pkg: shared state encoding and default width for the serial link
package simple_piso_tx_pkg;
  localparam int N_DEF = 4;
  typedef enum logic {TX_IDLE = 1'b0, TX_SHIFT = 1'b1} tx_state_t;
endpackage

// File: rtl/simple_bit_cnt.sv
// simple_bit_cnt: bit counter with clear, enable and terminal flag at N-1
module simple_bit_cnt
  import simple_piso_tx_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = $clog2(N)
) (
  input  logic ck,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);
  logic [CW-1:0] cnt;
  always_ff @(posedge ck or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign term = cnt == CW'(N - 1);
endmodule

// File: rtl/simple_piso_tx.sv
// simple_piso_tx: parallel-in serial-out transmitter, LSB first, valid/ready word load
module simple_piso_tx
  import simple_piso_tx_pkg::*;
#(
  parameter  int N  = N_DEF,
  localparam int CW = $clog2(N)
) (
  input  logic         ck,
  input  logic         rst,
  input  logic [N-1:0] din,
  input  logic         ld_v,
  output logic         ld_r,
  output logic         sout,
  output logic         sv,
  output logic         done
);
  tx_state_t    state;
  logic [N-1:0] sr;
  logic         term, acc, shift;
  assign shift = state == TX_SHIFT;
  assign done  = shift & term;
  // ready on the last bit too, so the next word follows with no idle gap
  assign ld_r  = ~rst & (~shift | term);
  assign acc   = ld_v & ld_r;
  assign sv    = shift;
  assign sout  = shift & sr[0];
  simple_bit_cnt #(.N(N), .CW(CW)) u_cnt (
    .ck  (ck),
    .rst (rst),
    .clr (acc | done),
    .en  (shift),
    .term(term)
  );
  always_ff @(posedge ck or posedge rst)
    if (rst) begin
      state <= TX_IDLE;
      sr    <= '0;
    end else if (acc) begin
      state <= TX_SHIFT;
      sr    <= din;
    end else if (shift) begin
      sr <= sr >> 1;
      if (term) state <= TX_IDLE;
    end
endmodule

// File: tb/tb_simple_piso_tx.sv
// tb_simple_piso_tx: N=4 and N=8 transmitters checked against a bits-remaining model
module tb_simple_piso_tx;
  logic       ck = 1'b0, rst = 1'b0;
  logic [3:0] din4 = '0;
  logic [7:0] din8 = '0;
  logic [1:0] ldv = '0, ldr, sout, sv, done;
  always #5 ck = ~ck;

  simple_piso_tx #(.N(4)) dut4 (.ck(ck), .rst(rst), .din(din4), .ld_v(ldv[0]), .ld_r(ldr[0]),
                                .sout(sout[0]), .sv(sv[0]), .done(done[0]));
  simple_piso_tx #(.N(8)) dut8 (.ck(ck), .rst(rst), .din(din8), .ld_v(ldv[1]), .ld_r(ldr[1]),
                                .sout(sout[1]), .sv(sv[1]), .done(done[1]));

  // model: a transmitter is just "which word, how many of its bits are still to go"
  int         rem [2] = '{0, 0};
  int         wr  [2] = '{0, 0};
  logic [7:0] cur [2];
  logic [7:0] words [2][256];
  function automatic int nn(int i); return i == 0 ? 4 : 8; endfunction
  function automatic logic [7:0] dword(int i); return i == 0 ? {4'b0, din4} : din8; endfunction
  function automatic logic m_ldr(int i); return !rst && rem[i] <= 1; endfunction
  always @(posedge ck or posedge rst)
    for (int i = 0; i < 2; i++)
      if (rst) rem[i] <= 0;
      else if (ldv[i] && m_ldr(i)) begin
        cur[i]            <= dword(i);
        rem[i]            <= nn(i);
        words[i][wr[i]]   <= dword(i);
        wr[i]             <= (wr[i] + 1) % 256;
      end else if (rem[i] > 0) rem[i] <= rem[i] - 1;

  int         nvec = 0, nerr = 0, cyc = 0;
  int         rd [2] = '{0, 0};
  logic [7:0] rx [2] = '{8'h0, 8'h0};
  logic [7:0] last_cap [2] = '{8'h0, 8'h0};
  logic       sv_log [4096], so_log [4096], dn_log [4096];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check();
    logic [7:0] nx, cap;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ld_r%0d", nn(i)), ldr[i], m_ldr(i));
      chk($sformatf("sv%0d", nn(i)), sv[i], rem[i] > 0);
      chk($sformatf("done%0d", nn(i)), done[i], rem[i] == 1);
      if (rem[i] > 0) chk($sformatf("sout%0d", nn(i)), sout[i], cur[i][nn(i) - rem[i]]);
      if (rst) begin
        rx[i] = '0;
        rd[i] = wr[i];
      end else if (sv[i]) begin
        nx    = {sout[i], rx[i][7:1]};
        rx[i] = nx;
        if (rem[i] == 1) begin
          cap         = i == 0 ? {4'b0, nx[7:4]} : nx;
          last_cap[i] = cap;
          chk($sformatf("rx%0d", nn(i)), cap, words[i][rd[i]]);
          rd[i] = (rd[i] + 1) % 256;
        end
      end
    end
    if (cyc < 4096) begin
      sv_log[cyc] = sv[0];
      so_log[cyc] = sout[0];
      dn_log[cyc] = done[0];
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge ck);
    @(negedge ck);
    check();
  endtask

  task automatic scan(input int a, output logic [15:0] bits, output int nsv, output int ndone,
                      output int span, output logic [15:0] dm);
    int first, last;
    first = -1; last = -1; bits = '0; dm = '0; nsv = 0; ndone = 0;
    for (int t = a; t < cyc && t < 4096; t++) begin
      if (dn_log[t]) ndone++;
      if (sv_log[t]) begin
        if (nsv < 16) begin
          bits[nsv] = so_log[t];
          dm[nsv]   = dn_log[t];
        end
        if (first < 0) first = t;
        last = t;
        nsv++;
      end
    end
    span = first < 0 ? 0 : last - first + 1;
  endtask

  initial begin
    logic [15:0] bits, dm;
    int          t0, nsv, ndone, span, n, base;
    #1 rst = 1'b1;
    tick();
    tick();
    chk("reset_ld_r", ldr[0], 0);
    chk("reset_sv", sv[0], 0);
    rst = 1'b0;
    tick();
    chk("idle_ld_r", ldr[0], 1);
    // single word
    t0 = cyc; din4 = 4'b1011; ldv[0] = 1'b1;
    tick();
    ldv[0] = 1'b0;
    repeat (6) tick();
    scan(t0, bits, nsv, ndone, span, dm);
    chk("single_bits", bits[3:0], 4'b1011);
    chk("single_nsv", nsv, 4);
    chk("single_done", dm[3:0], 4'b1000);
    chk("single_rx", last_cap[0], 8'h0b);
    // back-to-back
    t0 = cyc; din4 = 4'h3; ldv[0] = 1'b1;
    tick();
    din4 = 4'hc;
    repeat (4) tick();
    ldv[0] = 1'b0;
    repeat (6) tick();
    scan(t0, bits, nsv, ndone, span, dm);
    chk("b2b_bits", bits[7:0], 8'hc3);
    chk("b2b_nsv", nsv, 8);
    chk("b2b_span", span, 8);
    chk("b2b_done", dm[7:0], 8'h88);
    chk("b2b_rx", last_cap[0], 8'h0c);
    // busy ignore
    t0 = cyc; din4 = 4'h0; ldv[0] = 1'b1;
    tick();
    din4 = 4'hf;
    repeat (3) tick();
    ldv[0] = 1'b0;
    repeat (6) tick();
    scan(t0, bits, nsv, ndone, span, dm);
    chk("busy_bits", bits[3:0], 4'h0);
    chk("busy_nsv", nsv, 4);
    chk("busy_ndone", ndone, 1);
    // idle gap
    t0 = cyc; din4 = 4'h5; ldv[0] = 1'b1;
    tick();
    ldv[0] = 1'b0;
    repeat (6) tick();
    din4 = 4'h9; ldv[0] = 1'b1;
    tick();
    ldv[0] = 1'b0;
    repeat (6) tick();
    scan(t0, bits, nsv, ndone, span, dm);
    chk("gap_bits", bits[7:0], 8'h95);
    chk("gap_nsv", nsv, 8);
    chk("gap_ndone", ndone, 2);
    chk("gap_span", span, 11);
    chk("gap_rx", last_cap[0], 8'h09);
    // reset mid-word
    din4 = 4'ha; ldv[0] = 1'b1;
    tick();
    ldv[0] = 1'b0;
    tick();
    chk("prerst_sv", sv[0], 1);
    chk("prerst_sout", sout[0], 1);
    rst = 1'b1;
    #1;
    chk("rst_sv", sv[0], 0);
    chk("rst_sout", sout[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_ld_r", ldr[0], 0);
    tick();
    rst = 1'b0;
    tick();
    chk("postrst_ld_r", ldr[0], 1);
    chk("postrst_sv", sv[0], 0);
    // random words on both widths
    base = wr[1]; n = 0;
    while ((wr[1] - base + 256) % 256 < 100 && n < 5000) begin
      ldv[0] = $urandom_range(0, 3) != 0;
      din4   = 4'($urandom);
      ldv[1] = $urandom_range(0, 3) != 0;
      din8   = 8'($urandom);
      tick();
      n++;
    end
    chk("rand_budget", n < 5000, 1);
    ldv = '0;
    repeat (12) tick();
    chk("rand_drain", rd[1], wr[1]);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
